// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit: op size field, error codes,
// FSM states and the alignment rule.
package mips_lsu_pkg;

    localparam int OP_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Byte accesses are always aligned; the illegal size is never aligned.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (lane[0] == 1'b0);
            SZ_WORD: ok = (lane == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// CPU-side and memory-side bundles of the load/store unit. The LSU is the
// slave of the CPU bundle and the master of the memory bundle.
interface mips_lsu_cpu_if #(parameter int AW = 32);
    logic          req;
    logic          we;
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic [31:0]   rdata;
    logic [1:0]    err;

    modport master (output req, we, op, addr, wdata, input busy, done, rdata, err);
    modport slave  (input req, we, op, addr, wdata, output busy, done, rdata, err);
endinterface

interface mips_lsu_mem_if #(parameter int AW = 32);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/mips_lsu_fmt.sv
// Combinational data formatting: byte-enable generation, store-lane
// replication and little-endian load extraction with sign/zero extension.
module mips_lsu_fmt
    import mips_lsu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        uns_s;

    assign uns_s = op_i[OP_UNSIGNED_BIT];

    // Lane select of the returned word for sub-word loads.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (lane_i)
            2'b00:   byte_s = mem_rdata_i[7:0];
            2'b01:   byte_s = mem_rdata_i[15:8];
            2'b10:   byte_s = mem_rdata_i[23:16];
            2'b11:   byte_s = mem_rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane_i[1]) begin
            half_s = mem_rdata_i[31:16];
        end else begin
            half_s = mem_rdata_i[15:0];
        end
    end

    // Size-dependent enables, store replication and load extension.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
        case (op_i[1:0])
            SZ_BYTE: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = uns_s ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            end
            SZ_HALF: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = uns_s ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = mem_rdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
                rdata_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: IDLE/ACCESS/RESP controller with bounded memory wait,
// alignment and size checking, and registered CPU/memory outputs.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int AW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic           clk,
    input  logic           reset,
    mips_lsu_cpu_if.slave  cpu,
    mips_lsu_mem_if.master mem
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [1:0]    lane_q, lane_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          done_q, done_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    err_q, err_d;

    logic [2:0]    fmt_op_s;
    logic [1:0]    fmt_lane_s;
    logic [3:0]    fmt_be_s;
    logic [31:0]   fmt_wdata_s;
    logic [31:0]   fmt_rdata_s;

    // In IDLE the formatter sees the incoming request; afterwards the latched one.
    assign fmt_op_s   = (state_q == ST_IDLE) ? cpu.op : op_q;
    assign fmt_lane_s = (state_q == ST_IDLE) ? cpu.addr[1:0] : lane_q;

    mips_lsu_fmt u_fmt (
        .op_i        (fmt_op_s),
        .lane_i      (fmt_lane_s),
        .wdata_i     (cpu.wdata),
        .mem_rdata_i (mem.mem_rdata),
        .be_o        (fmt_be_s),
        .wdata_o     (fmt_wdata_s),
        .rdata_o     (fmt_rdata_s)
    );

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            op_q        <= 3'b000;
            lane_q      <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            done_q      <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-output logic; memory outputs are zero outside ACCESS.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        lane_d      = lane_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_be_d    = 4'b0000;
        mem_wdata_d = 32'h0000_0000;
        done_d      = 1'b0;
        rdata_d     = 32'h0000_0000;
        err_d       = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (!cpu.req) begin
                    state_d = ST_IDLE;
                end else if (cpu.op[1:0] == SZ_ILLEGAL) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    err_d   = ERR_ILLEGAL;
                end else if (!is_aligned(cpu.op[1:0], cpu.addr[1:0])) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    err_d   = ERR_MISALIGN;
                end else begin
                    state_d     = ST_ACCESS;
                    cnt_d       = 8'd0;
                    op_d        = cpu.op;
                    lane_d      = cpu.addr[1:0];
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu.we;
                    mem_addr_d  = {cpu.addr[AW-1:2], 2'b00};
                    mem_be_d    = fmt_be_s;
                    mem_wdata_d = fmt_wdata_s;
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ack) begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                    rdata_d = mem_we_q ? 32'h0000_0000 : fmt_rdata_s;
                    err_d   = ERR_NONE;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                    cnt_d   = cnt_q + 8'd1;
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    state_d     = ST_ACCESS;
                    cnt_d       = cnt_q + 8'd1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_be_d    = mem_be_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cpu.busy      = (state_q != ST_IDLE);
    assign cpu.done      = done_q;
    assign cpu.rdata     = rdata_q;
    assign cpu.err       = err_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed self-checking bench for mips_lsu: sub-word loads/stores, error
// responses, timeout boundary, ignored req/ack and mid-access reset.
module tb_mips_lsu;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    mips_lsu_cpu_if #(.AW(32)) cpu_if ();
    mips_lsu_mem_if #(.AW(32)) mem_if ();

    mips_lsu #(.AW(32), .MAX_WAIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu_if),
        .mem   (mem_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge, then withdraw it.
    task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd);
        cpu_if.req   = 1'b1;
        cpu_if.we    = we;
        cpu_if.op    = op;
        cpu_if.addr  = a;
        cpu_if.wdata = wd;
        step();
        cpu_if.req = 1'b0;
    endtask

    // Ack in the current ACCESS cycle and check the response cycle.
    task automatic ack_resp(input string tag, input logic [31:0] rd, input logic [31:0] exp_rd);
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = rd;
        step();
        mem_if.mem_ack = 1'b0;
        chk({tag, "_done"}, {31'd0, cpu_if.done}, 32'd1);
        chk({tag, "_rdata"}, cpu_if.rdata, exp_rd);
        chk({tag, "_err"}, {30'd0, cpu_if.err}, 32'd0);
        chk({tag, "_memreq_drop"}, {31'd0, mem_if.mem_req}, 32'd0);
        step();
        chk({tag, "_done_low"}, {31'd0, cpu_if.done}, 32'd0);
        chk({tag, "_rdata_low"}, cpu_if.rdata, 32'd0);
        chk({tag, "_idle"}, {31'd0, cpu_if.busy}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, cpu_if.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, cpu_if.done}, 32'd0);
        chk({tag, "_rdata"}, cpu_if.rdata, 32'd0);
        chk({tag, "_err"}, {30'd0, cpu_if.err}, 32'd0);
        chk({tag, "_mreq"}, {31'd0, mem_if.mem_req}, 32'd0);
        chk({tag, "_mwe"}, {31'd0, mem_if.mem_we}, 32'd0);
        chk({tag, "_maddr"}, mem_if.mem_addr, 32'd0);
        chk({tag, "_mbe"}, {28'd0, mem_if.mem_be}, 32'd0);
        chk({tag, "_mwdata"}, mem_if.mem_wdata, 32'd0);
    endtask

    initial begin
        int cyc;
        logic stable;
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.op = 3'b000;
        cpu_if.addr = 32'd0; cpu_if.wdata = 32'd0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'd0;

        step(); step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        // LB 0x103: lane 3 holds 0x80 -> sign-extended.
        issue(1'b0, 3'b000, 32'h0000_0103, 32'd0);
        chk("lb_memreq", {31'd0, mem_if.mem_req}, 32'd1);
        chk("lb_be", {28'd0, mem_if.mem_be}, 32'h8);
        chk("lb_addr", mem_if.mem_addr, 32'h0000_0100);
        chk("lb_we", {31'd0, mem_if.mem_we}, 32'd0);
        chk("lb_busy", {31'd0, cpu_if.busy}, 32'd1);
        chk("lb_nodone", {31'd0, cpu_if.done}, 32'd0);
        ack_resp("lb", 32'h80FF_1234, 32'hFFFF_FF80);

        // LHU / LH 0x102: upper half 0x9ABC.
        issue(1'b0, 3'b101, 32'h0000_0102, 32'd0);
        chk("lhu_be", {28'd0, mem_if.mem_be}, 32'hC);
        ack_resp("lhu", 32'h9ABC_5678, 32'h0000_9ABC);
        issue(1'b0, 3'b001, 32'h0000_0102, 32'd0);
        chk("lh_be", {28'd0, mem_if.mem_be}, 32'hC);
        ack_resp("lh", 32'h9ABC_5678, 32'hFFFF_9ABC);

        // LBU lane 0 and LW word.
        issue(1'b0, 3'b100, 32'h0000_0100, 32'd0);
        chk("lbu_be", {28'd0, mem_if.mem_be}, 32'h1);
        ack_resp("lbu", 32'h1234_56F0, 32'h0000_00F0);
        issue(1'b0, 3'b110, 32'h0000_0108, 32'd0);
        chk("lw_be", {28'd0, mem_if.mem_be}, 32'hF);
        ack_resp("lw", 32'h8765_4321, 32'h8765_4321);

        // SB 0x201: replicated data, store returns rdata 0.
        issue(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5);
        chk("sb_we", {31'd0, mem_if.mem_we}, 32'd1);
        chk("sb_addr", mem_if.mem_addr, 32'h0000_0200);
        chk("sb_be", {28'd0, mem_if.mem_be}, 32'h2);
        chk("sb_wdata", mem_if.mem_wdata, 32'hA5A5_A5A5);
        ack_resp("sb", 32'hDEAD_BEEF, 32'd0);

        // SH 0x202.
        issue(1'b1, 3'b001, 32'h0000_0202, 32'hFFFF_BEEF);
        chk("sh_be", {28'd0, mem_if.mem_be}, 32'hC);
        chk("sh_wdata", mem_if.mem_wdata, 32'hBEEF_BEEF);
        ack_resp("sh", 32'h0, 32'd0);

        // Error responses: misaligned word, illegal size, illegal beats misaligned.
        issue(1'b0, 3'b010, 32'h0000_0106, 32'd0);
        chk("mis_done", {31'd0, cpu_if.done}, 32'd1);
        chk("mis_err", {30'd0, cpu_if.err}, 32'd1);
        chk("mis_nomreq", {31'd0, mem_if.mem_req}, 32'd0);
        step();
        chk("mis_done_low", {31'd0, cpu_if.done}, 32'd0);
        chk("mis_err_low", {30'd0, cpu_if.err}, 32'd0);
        issue(1'b0, 3'b011, 32'h0000_0100, 32'd0);
        chk("ill_err", {30'd0, cpu_if.err}, 32'd3);
        chk("ill_nomreq", {31'd0, mem_if.mem_req}, 32'd0);
        step();
        issue(1'b1, 3'b111, 32'h0000_0101, 32'd0);
        chk("illmis_err", {30'd0, cpu_if.err}, 32'd3);
        step();
        issue(1'b0, 3'b001, 32'h0000_0103, 32'd0);
        chk("mis_half_err", {30'd0, cpu_if.err}, 32'd1);
        step();

        // Stray ack in IDLE is ignored.
        mem_if.mem_ack = 1'b1;
        step();
        mem_if.mem_ack = 1'b0;
        chk("stray_ack_busy", {31'd0, cpu_if.busy}, 32'd0);
        chk("stray_ack_done", {31'd0, cpu_if.done}, 32'd0);

        // Timeout: mem_req high exactly 15 cycles, address held stable.
        issue(1'b0, 3'b010, 32'h0000_0300, 32'd0);
        cyc = 0;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!mem_if.mem_req) break;
            cyc++;
            if (mem_if.mem_addr !== 32'h0000_0300 || mem_if.mem_be !== 4'hF) stable = 1'b0;
            step();
        end
        chk("to_cycles", cyc, 32'd15);
        chk("to_stable", {31'd0, stable}, 32'd1);
        chk("to_done", {31'd0, cpu_if.done}, 32'd1);
        chk("to_err", {30'd0, cpu_if.err}, 32'd2);
        step();
        chk("to_done_low", {31'd0, cpu_if.done}, 32'd0);

        // Ack on the 15th cycle wins; req during ACCESS is ignored.
        issue(1'b0, 3'b010, 32'h0000_0304, 32'd0);
        cpu_if.req = 1'b1; cpu_if.op = 3'b011; cpu_if.addr = 32'h0000_0555;
        for (int i = 0; i < 14; i++) step();
        cpu_if.req = 1'b0;
        chk("late_busy", {31'd0, cpu_if.busy}, 32'd1);
        chk("late_mreq", {31'd0, mem_if.mem_req}, 32'd1);
        chk("late_addr", mem_if.mem_addr, 32'h0000_0304);
        chk("late_nodone", {31'd0, cpu_if.done}, 32'd0);
        ack_resp("late", 32'h1122_3344, 32'h1122_3344);

        // Reset in the 3rd ACCESS cycle of a store, with a simultaneous ack.
        issue(1'b1, 3'b010, 32'h0000_0400, 32'h1234_5678);
        step(); step();
        chk("rst_pre_mwdata", mem_if.mem_wdata, 32'h1234_5678);
        reset = 1'b1;
        mem_if.mem_ack = 1'b1;
        step();
        reset = 1'b0;
        mem_if.mem_ack = 1'b0;
        chk_all_zero("midrst");
        step();
        chk("midrst_nodone", {31'd0, cpu_if.done}, 32'd0);
        issue(1'b0, 3'b110, 32'h0000_0404, 32'd0);
        chk("post_rst_addr", mem_if.mem_addr, 32'h0000_0404);
        ack_resp("post_rst", 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
